// File: rtl/mult_sequencer.sv
// mult_sequencer: iterative shift-add mult/multu with PC stall; define MULT_EARLY_TERM_EN to finish RUN once the multiplier is exhausted
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] mcand, mplier, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [CW-1:0] cnt;
  logic neg_flag, last;
  assign mag_a = (is_signed & op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (is_signed & op_b[WIDTH-1]) ? -op_b : op_b;
  assign acc_nx = acc + (mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
`ifdef MULT_EARLY_TERM_EN
  assign last = (&cnt) | (mplier[WIDTH-1:1] == '0);
`else
  assign last = &cnt;
`endif
  assign stall = ((state == IDLE) & start) | (state == RUN);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      prod_hi  <= '0;
      prod_lo  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand    <= mag_a;
          mplier   <= mag_b;
          neg_flag <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc      <= '0;
          cnt      <= '0;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          acc    <= acc_nx;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            {prod_hi, prod_lo} <= neg_flag ? -acc_nx : acc_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Iterative shift-add multiply sequencer for the `mult`/`multu` R-type functions. The instruction decoder flags these functions with `fpoint = 2'b11`. This block sits beside the ALU: it accepts a start pulse and operands, holds the PC through `stall` while it iterates, and then presents a 64-bit product for the register-file write.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The product is 2*`WIDTH`. `WIDTH` must be a power of two, ≥ 4.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to multiply. Sampled only in IDLE.
- `is_signed`  in  1  1 = `mult` (two's complement), 0 = `multu`. Sampled with `start`.
- `op_a`  in  `WIDTH`  multiplicand (rs1 data). Sampled with `start`.
- `op_b`  in  `WIDTH`  multiplier (rs2 data). Sampled with `start`.
- `stall`  out  1  hold PC and suppress regwrite while high.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `prod_lo`  out  `WIDTH`  product bits [`WIDTH`-1:0].
- `prod_hi`  out  `WIDTH`  product bits [2*`WIDTH`-1:`WIDTH`].

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- **IDLE**
  - `start`=1 latches the operand magnitudes into `mcand`/`mplier`. For signed operands the magnitude is |x|; `-2^(WIDTH-1)` maps to `2^(WIDTH-1)` unsigned.
  - `neg_flag` = `is_signed` & (`op_a`[MSB] ^ `op_b`[MSB]).
  - The 2*`WIDTH` accumulator and the iteration counter clear to 0. Next state is RUN.
- **RUN**, once per cycle:
  - If `mplier`[0]=1, `acc` += `mcand` << count, computed at 2*`WIDTH` width. Carries are never lost.
  - `mplier` shifts right by one; count increments.
  - After the iteration with count = `WIDTH`-1, go to DONE.
- **DONE**
  - `{prod_hi,prod_lo}` = `neg_flag` ? two's-complement negation of `acc` : `acc`. The value is registered on entry to DONE.
  - `done`=1 for exactly this cycle. The next state is always IDLE.
  - `start` is not accepted in DONE.
- `start` while in RUN or DONE is ignored. No queueing. The decoder keeps re-issuing because the PC is stalled.
- `prod_hi`/`prod_lo` hold their last value until the next DONE.
- Low-word identity: `prod_lo` is the same for `mult` and `multu` on identical bit patterns. Only `prod_hi` differs.
- Reset, asynchronous and at any time including mid-RUN:
  - State goes to IDLE; `acc`, `mcand`, `mplier`, count and `neg_flag` clear to 0.
  - `prod_hi`=0, `prod_lo`=0, `done`=0, `busy`=0.
  - `stall` follows the combinational rule below.

## Timing
- `stall` = (IDLE & `start`) | RUN. It is combinational from `start` so the PC does not advance at the accepting edge.
- `stall` is 0 in DONE. The PC advances at the end of the DONE cycle, and the register file writes `prod_*` in that same cycle.
- Latency without early termination:
  - Start is accepted at edge 0.
  - RUN occupies cycles 1..`WIDTH`.
  - DONE is cycle `WIDTH`+1 (33 for `WIDTH`=32).
  - `stall` is high for `WIDTH`+1 cycles in total (the accept cycle plus RUN).
- Back-to-back multiplies: the earliest next `start` acceptance is the cycle after DONE. Throughput is one product per `WIDTH`+2 cycles.
- `busy` and `done` are registered outputs, decoded from state.

## Configuration
- `MULT_EARLY_TERM_EN`
  - **Defined:** in RUN, if the post-shift `mplier` is 0, go to DONE immediately, regardless of count.
    - Latency becomes (index of the highest set bit of |`op_b`|)+1 RUN cycles, minimum 1. `op_b`=0 gives 1 RUN cycle and DONE at cycle 2.
    - Results are identical to the undefined build.
  - **Undefined:** always exactly `WIDTH` RUN cycles.

## Test plan
- **Unsigned multiply.** `multu`, `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF.
  - `prod_hi`=0xFFFFFFFE, `prod_lo`=0x00000001.
  - `done` in cycle 33; `stall` high for cycles 0–32.
- **Signed multiply.** `mult`, `op_a`=0xFFFFFFFE (−2), `op_b`=0x00000003.
  - `prod_hi`=0xFFFFFFFF, `prod_lo`=0xFFFFFFFA.
  - Repeat as `multu`: `prod_hi`=0x00000002, `prod_lo`=0xFFFFFFFA.
- **Most-negative operands.** `mult`, 0x80000000 × 0x80000000: `prod_hi`=0x40000000, `prod_lo`=0.
- **Start ignored while busy.** Hold `start`=1 for 40 cycles with operands changing after cycle 0.
  - The first product is computed from the cycle-0 operands.
  - A second acceptance occurs at cycle 34.
- **Reset mid-operation.** Assert `reset` at cycle 10 of RUN.
  - All outputs go to 0 immediately; state is IDLE.
  - The next `start` gives a fresh, correct product 5×7=35.
- **Early termination.** With `MULT_EARLY_TERM_EN`: `op_b`=0 gives `done` at cycle 2; `op_b`=0x10 gives `done` at cycle 6.
  - Without the macro, both cases give `done` at cycle 33 with identical products.
